// File: rtl/tile_ser_pkg.sv
// Shared geometry, counter sizing and FSM state type for the tile raster serializer.
package tile_ser_pkg;

    localparam int M          = 4 - 3 + 1;
    localparam int TPR        = 8 / M;
    localparam int TROWS      = 8 / M;
    localparam int ACC_WIDTH  = 8 + 8 + 13;

    function automatic int ctr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } ser_state_t;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic shift, clamp negatives to zero, saturate to the pixel range.
module requant_sat #(
    parameter int ACC_WIDTH      = 29,
    parameter int OUT_DATA_WIDTH = 8,
    parameter int SHIFT          = 0
) (
    input  logic signed [ACC_WIDTH-1:0]      acc,
    output logic        [OUT_DATA_WIDTH-1:0] pix
);

    logic signed [ACC_WIDTH-1:0] v;

    always_comb begin
        v = acc >>> SHIFT;
        if (v[ACC_WIDTH-1]) begin
            pix = '0;
        end else if (|v[ACC_WIDTH-2:OUT_DATA_WIDTH]) begin
            pix = '1;
        end else begin
            pix = v[OUT_DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/tile_raster_serializer.sv
// Collects one row of requantized output tiles into a line buffer, then streams it out in raster order.
module tile_raster_serializer #(
    parameter int KERNEL_SIZE         = 3,
    parameter int INPUT_TILE_SIZE     = 4,
    parameter int INPUT_DATA_WIDTH    = 8,
    parameter int KERNEL_DATA_WIDTH   = 8,
    parameter int ACC_WIDTH           = KERNEL_DATA_WIDTH + INPUT_DATA_WIDTH + 13,
    parameter int OUTPUT_IMAGE_WIDTH  = 8,
    parameter int OUTPUT_IMAGE_HEIGHT = 8,
    parameter int OUT_DATA_WIDTH      = 8,
    parameter int SHIFT               = 0
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [(INPUT_TILE_SIZE-KERNEL_SIZE+1)*(INPUT_TILE_SIZE-KERNEL_SIZE+1)*ACC_WIDTH-1:0] i_tile_data,
    input  logic                                                   i_tile_valid,
    output logic                                                   o_tile_ready,
    output logic [OUT_DATA_WIDTH-1:0]                              o_pixel_data,
    output logic                                                   o_pixel_valid,
    input  logic                                                   i_pixel_ready,
    output logic                                                   o_pixel_eol,
    output logic                                                   o_frame_done
);
    import tile_ser_pkg::*;

    localparam int TILE_M    = INPUT_TILE_SIZE - KERNEL_SIZE + 1;
    localparam int ROW_TILES = OUTPUT_IMAGE_WIDTH / TILE_M;
    localparam int TILE_ROWS = OUTPUT_IMAGE_HEIGHT / TILE_M;
    localparam int TCW       = ctr_w(ROW_TILES);
    localparam int TRW       = ctr_w(TILE_ROWS);
    localparam int LW        = ctr_w(TILE_M);

    localparam logic [TCW-1:0] LAST_TCOL = TCW'(ROW_TILES - 1);
    localparam logic [TRW-1:0] LAST_TROW = TRW'(TILE_ROWS - 1);
    localparam logic [LW-1:0]  LAST_SUB  = LW'(TILE_M - 1);

    typedef logic [TILE_M-1:0][OUT_DATA_WIDTH-1:0] group_t;

    ser_state_t     state_q, state_d;
    logic [TCW-1:0] tcol_q, tcol_d;
    logic [TRW-1:0] trow_q, trow_d;
    logic [LW-1:0]  line_q, line_d;
    logic [TCW-1:0] xt_q, xt_d;
    logic [LW-1:0]  xs_q, xs_d;
    logic           tile_ready_q, pix_valid_q, frame_done_q, frame_done_d;
    logic           tile_accept, pix_accept, at_eol, at_last;

    logic [TILE_M-1:0][TILE_M-1:0][OUT_DATA_WIDTH-1:0] wr_pix;
    logic [TILE_M-1:0][TILE_M-1:0][OUT_DATA_WIDTH-1:0] rd_group;

    // Each buffer line is stored as groups of M pixels, one group per tile column;
    // the drain x position is kept as (group, offset) to avoid a divide by M.
    for (genvar r = 0; r < TILE_M; r++) begin : g_line
        group_t mem [ROW_TILES];

        for (genvar c = 0; c < TILE_M; c++) begin : g_col
            requant_sat #(
                .ACC_WIDTH      (ACC_WIDTH),
                .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
                .SHIFT          (SHIFT)
            ) u_requant (
                .acc (i_tile_data[(r*TILE_M+c)*ACC_WIDTH +: ACC_WIDTH]),
                .pix (wr_pix[r][c])
            );
        end

        always_ff @(posedge clk) begin
            if (tile_accept) begin
                mem[tcol_q] <= wr_pix[r];
            end
        end

        assign rd_group[r] = mem[xt_q];
    end

    assign tile_accept = !reset && (state_q == FILL) && tile_ready_q && i_tile_valid;
    assign pix_accept  = (state_q == DRAIN) && pix_valid_q && i_pixel_ready;
    assign at_eol      = (xt_q == LAST_TCOL) && (xs_q == LAST_SUB);
    assign at_last     = at_eol && (line_q == LAST_SUB);

    always_comb begin
        state_d      = state_q;
        tcol_d       = tcol_q;
        trow_d       = trow_q;
        line_d       = line_q;
        xt_d         = xt_q;
        xs_d         = xs_q;
        frame_done_d = 1'b0;
        if (state_q == FILL) begin
            if (tile_accept) begin
                if (tcol_q == LAST_TCOL) begin
                    tcol_d  = '0;
                    state_d = DRAIN;
                end else begin
                    tcol_d = tcol_q + 1'b1;
                end
            end
        end else if (pix_accept) begin
            if (at_last) begin
                line_d  = '0;
                xt_d    = '0;
                xs_d    = '0;
                state_d = FILL;
                if (trow_q == LAST_TROW) begin
                    trow_d       = '0;
                    frame_done_d = 1'b1;
                end else begin
                    trow_d = trow_q + 1'b1;
                end
            end else if (at_eol) begin
                xt_d   = '0;
                xs_d   = '0;
                line_d = line_q + 1'b1;
            end else if (xs_q == LAST_SUB) begin
                xs_d = '0;
                xt_d = xt_q + 1'b1;
            end else begin
                xs_d = xs_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            tcol_q       <= '0;
            trow_q       <= '0;
            line_q       <= '0;
            xt_q         <= '0;
            xs_q         <= '0;
            tile_ready_q <= 1'b1;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcol_q       <= tcol_d;
            trow_q       <= trow_d;
            line_q       <= line_d;
            xt_q         <= xt_d;
            xs_q         <= xs_d;
            tile_ready_q <= (state_d == FILL);
            pix_valid_q  <= (state_d == DRAIN);
            frame_done_q <= frame_done_d;
        end
    end

    assign o_tile_ready  = tile_ready_q;
    assign o_pixel_valid = pix_valid_q;
    assign o_pixel_data  = pix_valid_q ? rd_group[line_q][xs_q] : '0;
    assign o_pixel_eol   = pix_valid_q && at_eol;
    assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_tile_raster_serializer.sv
// Bench for tile_raster_serializer: two instances (SHIFT 0 and 1) checked every cycle against a queue-based model.
module tb_tile_raster_serializer;
    import tile_ser_pkg::*;

    localparam int W     = TPR * M;
    localparam int OUT_W = 8;
    localparam int PMAX  = (1 << OUT_W) - 1;
    localparam int TW    = M * M * ACC_WIDTH;

    typedef struct {
        int p0;
        int p1;
        bit eol;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [TW-1:0]    i_tile_data;
    logic             i_tile_valid;
    logic             i_pixel_ready;
    logic             tr0, pv0, eol0, fd0;
    logic             tr1, pv1, eol1, fd1;
    logic [OUT_W-1:0] pd0, pd1;

    always #5 clk = ~clk;

    tile_raster_serializer #(.SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .i_tile_data(i_tile_data), .i_tile_valid(i_tile_valid),
        .o_tile_ready(tr0), .o_pixel_data(pd0), .o_pixel_valid(pv0), .i_pixel_ready(i_pixel_ready),
        .o_pixel_eol(eol0), .o_frame_done(fd0)
    );

    tile_raster_serializer #(.SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .i_tile_data(i_tile_data), .i_tile_valid(i_tile_valid),
        .o_tile_ready(tr1), .o_pixel_data(pd1), .o_pixel_valid(pv1), .i_pixel_ready(i_pixel_ready),
        .o_pixel_eol(eol1), .o_frame_done(fd1)
    );

    int    checks = 0;
    int    errors = 0;
    bit    checking = 0;
    int    ready_mode = 0;
    int    pulses = 0;
    int    log0[$];
    int    log1[$];
    bit    eollog[$];

    exp_t   expq[$];
    longint row_acc [M][W];
    int     m_tiles = 0;
    int     m_rows = 0;
    bit     m_ready = 1;
    bit     m_valid = 0;
    bit     m_done = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rq(input longint a, input int sh);
        longint v;
        v = a >>> sh;
        if (v < 0) return 0;
        if (v > PMAX) return PMAX;
        return int'(v);
    endfunction

    // Reference: a tile row becomes a queue of raster pixels; the block drains while the queue is non-empty.
    always @(posedge clk) begin : model
        logic signed [ACC_WIDTH-1:0] e;
        exp_t x;
        bit was_ready, was_valid;
        if (reset) begin
            expq.delete();
            m_tiles = 0;
            m_rows  = 0;
            m_ready = 1;
            m_valid = 0;
            m_done  = 0;
        end else begin
            was_ready = m_ready;
            was_valid = m_valid;
            m_done = 0;
            if (was_valid && i_pixel_ready) begin
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    m_rows++;
                    if (m_rows == TROWS) begin
                        m_rows = 0;
                        m_done = 1;
                    end
                end
            end
            if (was_ready && i_tile_valid) begin
                for (int r = 0; r < M; r++) begin
                    for (int c = 0; c < M; c++) begin
                        e = i_tile_data[(r*M+c)*ACC_WIDTH +: ACC_WIDTH];
                        row_acc[r][m_tiles*M+c] = e;
                    end
                end
                m_tiles++;
                if (m_tiles == TPR) begin
                    m_tiles = 0;
                    for (int ln = 0; ln < M; ln++) begin
                        for (int px = 0; px < W; px++) begin
                            x.p0  = rq(row_acc[ln][px], 0);
                            x.p1  = rq(row_acc[ln][px], 1);
                            x.eol = (px == W - 1);
                            expq.push_back(x);
                        end
                    end
                end
            end
            m_valid = (expq.size() != 0);
            m_ready = !m_valid;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("tile_ready0", tr0, m_ready);
            check("tile_ready1", tr1, m_ready);
            check("pixel_valid0", pv0, m_valid);
            check("pixel_valid1", pv1, m_valid);
            check("frame_done0", fd0, m_done);
            check("frame_done1", fd1, m_done);
            if (m_valid) begin
                check("pixel0", pd0, expq[0].p0);
                check("pixel1", pd1, expq[0].p1);
                check("eol0", eol0, expq[0].eol);
                check("eol1", eol1, expq[0].eol);
            end
            if (pv0 && i_pixel_ready) begin
                log0.push_back(int'(pd0));
                log1.push_back(int'(pd1));
                eollog.push_back(eol0);
            end
            if (fd0) pulses++;
        end
    end

    initial begin : ready_driver
        bit pat [4] = '{1, 0, 0, 1};
        int pi = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_pixel_ready = 1'b1;
                1: begin
                    i_pixel_ready = pat[pi];
                    pi = (pi + 1) % 4;
                end
                default: i_pixel_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [TW-1:0] mk_tile(input int t);
        logic [TW-1:0] d;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                d[(r*M+c)*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(16 * t + 4 * r + c);
        return d;
    endfunction

    function automatic logic [TW-1:0] mk4(input longint v0, input longint v1, input longint v2, input longint v3);
        logic [TW-1:0] d;
        d = '0;
        d[0*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v0);
        d[1*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v1);
        d[2*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v2);
        d[3*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(v3);
        return d;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] d;
        logic [ACC_WIDTH-1:0] e;
        for (int unsigned k = 0; k < M * M; k++) begin
            case ($urandom_range(0, 3))
                0: e = ACC_WIDTH'($urandom);
                1: e = ACC_WIDTH'($urandom_range(0, 600));
                2: e = '0 - ACC_WIDTH'($urandom_range(1, 600));
                default: e = ACC_WIDTH'($urandom_range(250, 520));
            endcase
            d[k*ACC_WIDTH +: ACC_WIDTH] = e;
        end
        return d;
    endfunction

    task automatic send_tile(input logic [TW-1:0] d);
        int unsigned n = 0;
        bit took = 0;
        i_tile_data  = d;
        i_tile_valid = 1'b1;
        while (!took) begin
            @(negedge clk);
            took = tr0;
            @(posedge clk);
            #1;
            n++;
            if (!took && n > 300) begin
                check("tile_accept_timeout", 0, 1);
                took = 1;
            end
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        i_tile_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while ((expq.size() != 0 || !m_ready) && n < 500);
        if (n >= 500) check("drain_timeout", 0, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    int pat_l  [16] = '{0, 1, 16, 17, 32, 33, 48, 49, 4, 5, 20, 21, 36, 37, 52, 53};
    int sat0_l [16] = '{0, 255, 255, 255, 0, 0, 0, 0, 255, 255, 0, 0, 0, 0, 0, 0};
    int sat1_l [16] = '{0, 127, 255, 150, 0, 0, 0, 0, 128, 255, 0, 0, 0, 0, 0, 0};

    task automatic check_pattern_row(input string name, input int base);
        check({name, "_count"}, log0.size() - base, 16);
        for (int i = 0; i < 16; i++) check({name, "_pix"}, log0[base + i], pat_l[i]);
        check({name, "_eol_l0"}, eollog[base + 7], 1);
        check({name, "_eol_l1"}, eollog[base + 15], 1);
        check({name, "_noeol"}, eollog[base + 6], 0);
    endtask

    initial begin : main
        int base, p_start;
        logic [TW-1:0] frame_tiles [TPR * TROWS];

        reset = 1'b1;
        i_tile_valid = 1'b0;
        i_tile_data = '0;
        i_pixel_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checking = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        check("rq_neg", rq(-5, 0), 0);
        check("rq_255", rq(255, 0), 255);
        check("rq_256", rq(256, 0), 255);
        check("rq_big", rq(longint'(1) << 28 - 1, 0) == 255 ? rq((longint'(1) << 28) - 1, 0) : -1, 255);
        check("rq_511_s1", rq(511, 1), 255);
        check("rq_300_s1", rq(300, 1), 150);

        // element mapping with ready held high
        base = log0.size();
        for (int t = 0; t < TPR; t++) send_tile(mk_tile(t));
        wait_idle();
        check_pattern_row("map", base);

        // backpressure pattern 1,0,0,1
        ready_mode = 1;
        base = log0.size();
        for (int t = 0; t < TPR; t++) send_tile(mk_tile(t));
        wait_idle();
        check_pattern_row("bp", base);

        // saturation in both shift settings
        ready_mode = 0;
        base = log0.size();
        send_tile(mk4(-5, 255, 256, (longint'(1) << 28) - 1));
        send_tile(mk4(511, 300, 0, -1));
        send_tile('0);
        send_tile('0);
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            check("sat_s0", log0[base + i], sat0_l[i]);
            check("sat_s1", log1[base + i], sat1_l[i]);
        end

        // tile presented during drain is held and becomes tcol 0 of the next row
        ready_mode = 2;
        base = log0.size();
        for (int t = 0; t < TPR; t++) send_tile(rand_tile());
        send_tile(mk4(77, 77, 77, 77));
        for (int t = 1; t < TPR; t++) send_tile(rand_tile());
        wait_idle();
        check("marker_l0x0", log0[base + W * M], 77);
        check("marker_l0x1", log0[base + W * M + 1], 77);
        check("marker_l1x0", log0[base + W * M + W], 77);
        for (int rr = 0; rr < TROWS - 1; rr++) begin
            for (int t = 0; t < TPR; t++) send_tile(rand_tile());
            wait_idle();
        end

        // two full frames, tiles back-to-back; second run replays the same tiles
        for (int i = 0; i < TPR * TROWS; i++) frame_tiles[i] = rand_tile();
        for (int f = 0; f < 2; f++) begin
            ready_mode = (f == 0) ? 0 : 2;
            base = log0.size();
            p_start = pulses;
            for (int i = 0; i < TPR * TROWS; i++) send_tile(frame_tiles[i]);
            wait_idle();
            check("frame_pixels", log0.size() - base, W * M * TROWS);
            check("frame_pulses", pulses - p_start, 1);
        end

        // reset during drain, then a clean row
        ready_mode = 0;
        base = log0.size();
        for (int t = 0; t < TPR; t++) send_tile(mk_tile(t));
        i_tile_valid = 1'b0;
        for (int n = 0; n < 100 && log0.size() < base + 5; n++) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", pv0, 0);
        check("rst_ready", tr0, 1);
        @(posedge clk);
        #1;
        base = log0.size();
        for (int t = 0; t < TPR; t++) send_tile(mk_tile(t));
        wait_idle();
        check_pattern_row("after_rst", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
